// File: rtl/mul.sv
// MIX MUL radix-8 shift-and-add multiplier: start/stop handshake, 60-bit magnitude plus sign.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the RUN phase and stops one cycle after accept.
//
// state  | meaning
// S_IDLE | waiting for start (busy=0)
// S_RUN  | one octal digit of the multiplier consumed per cycle (busy=1)
module mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [30:0] multiplicand,
    input  logic [30:0] multiplier,
    output logic [59:0] product,
    output logic        sign,
    output logic        stop
);

    localparam int          DIGITS   = 10;
    localparam logic [3:0]  LAST_CNT = 4'(DIGITS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [59:0] r_acc;
    logic [29:0] r_mcand;
    logic [29:0] r_mplier;
    logic [3:0]  r_cnt;
    logic        r_sign;
    logic        r_done;
    logic        r_stop;

    logic        w_busy;
    logic        w_accept;
    logic        w_last;
    logic        w_zero;
    logic        w_done_set;
    logic [32:0] w_pp;
    logic [59:0] w_acc_nxt;

`ifdef MUL_ZERO_BYPASS_EN
    assign w_zero = (multiplicand[29:0] == 30'd0) || (multiplier[29:0] == 30'd0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && !w_zero) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST_CNT) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == S_RUN);
        w_accept   = (r_state == S_IDLE) && start;
        w_last     = w_busy && (r_cnt == LAST_CNT);
        w_done_set = w_last || (w_accept && w_zero);
    end

    // Partial product is 33 bits and zero-extended into the shifted accumulator.
    assign w_pp      = {3'b000, r_mcand} * {30'd0, r_mplier[29:27]};
    assign w_acc_nxt = {r_acc[56:0], 3'b000} + {27'd0, w_pp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= 60'd0;
            r_mcand  <= 30'd0;
            r_mplier <= 30'd0;
            r_cnt    <= 4'd0;
            r_sign   <= 1'b0;
            r_done   <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_stop <= r_done;
            if (w_accept) begin
                r_sign   <= multiplicand[30] ^ multiplier[30];
                r_mcand  <= multiplicand[29:0];
                r_mplier <= multiplier[29:0];
                r_acc    <= 60'd0;
                r_cnt    <= 4'd0;
            end else if (w_busy) begin
                r_acc    <= w_acc_nxt;
                r_mplier <= {r_mplier[26:0], 3'b000};
                r_cnt    <= r_cnt + 4'd1;
            end
        end
    end

    assign product = r_acc;
    assign sign    = r_sign;
    assign stop    = r_stop;

endmodule

// File: tb/tb_mul.sv
// Directed bench for mul: latency, product, sign, busy protection, reset abort, back-to-back.
module tb_mul;

    logic        clk;
    logic        reset;
    logic        start;
    logic [30:0] multiplicand;
    logic [30:0] multiplier;
    logic [59:0] product;
    logic        sign;
    logic        stop;

    int errors = 0;
    int checks = 0;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 11;
`endif

    mul dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .sign         (sign),
        .stop         (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then watch a bounded window for stop.
    task automatic run_op(input logic [30:0] a, input logic [30:0] b,
                          output int lat, output int pulses);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 31'h7FFF_FFFF;
        multiplier   = 31'h5555_5555;
        lat    = -1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (stop) begin
                if (lat < 0) lat = k;
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        multiplicand = 31'd0;
        multiplier   = 31'd0;
        tick();
        tick();
        checks++; if (product !== 60'd0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
        checks++; if (sign !== 1'b0)     begin errors++; $display("FAIL reset_sign got=%b exp=0", sign); end
        checks++; if (stop !== 1'b0)     begin errors++; $display("FAIL reset_stop got=%b exp=0", stop); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, pulses;
        run_op({1'b0, 30'd3}, {1'b0, 30'd5}, lat, pulses);
        checks++; if (lat !== 11)         begin errors++; $display("FAIL basic_latency got=%0d exp=11", lat); end
        checks++; if (pulses !== 1)       begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
        checks++; if (product !== 60'd15) begin errors++; $display("FAIL basic_product got=%0d exp=15", product); end
        checks++; if (sign !== 1'b0)      begin errors++; $display("FAIL basic_sign got=%b exp=0", sign); end
        run_op({1'b0, 30'd12345}, {1'b0, 30'd6789}, lat, pulses);
        checks++; if (product !== 60'd83810205) begin errors++; $display("FAIL mid_product got=%0d exp=83810205", product); end
    endtask

    task automatic test_max();
        int lat, pulses;
        run_op({1'b0, 30'h3FFF_FFFF}, {1'b0, 30'h3FFF_FFFF}, lat, pulses);
        checks++; if (lat !== 11) begin errors++; $display("FAIL max_latency got=%0d exp=11", lat); end
        checks++; if (product !== 60'hFFF_FFFF_8000_0001) begin errors++; $display("FAIL max_product got=%h exp=fffffff80000001", product); end
        checks++; if (sign !== 1'b0) begin errors++; $display("FAIL max_sign got=%b exp=0", sign); end
    endtask

    task automatic test_sign();
        int lat, pulses;
        run_op({1'b1, 30'd7}, {1'b0, 30'd6}, lat, pulses);
        checks++; if (product !== 60'd42) begin errors++; $display("FAIL sign_mp_product got=%0d exp=42", product); end
        checks++; if (sign !== 1'b1)      begin errors++; $display("FAIL sign_mp_sign got=%b exp=1", sign); end
        run_op({1'b1, 30'd7}, {1'b1, 30'd6}, lat, pulses);
        checks++; if (product !== 60'd42) begin errors++; $display("FAIL sign_mm_product got=%0d exp=42", product); end
        checks++; if (sign !== 1'b0)      begin errors++; $display("FAIL sign_mm_sign got=%b exp=0", sign); end
    endtask

    task automatic test_zero();
        int lat, pulses;
        run_op({1'b0, 30'd0}, {1'b1, 30'd5}, lat, pulses);
        checks++; if (lat !== ZERO_LAT)  begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, ZERO_LAT); end
        checks++; if (pulses !== 1)      begin errors++; $display("FAIL zero_pulses got=%0d exp=1", pulses); end
        checks++; if (product !== 60'd0) begin errors++; $display("FAIL zero_product got=%0d exp=0", product); end
        checks++; if (sign !== 1'b1)     begin errors++; $display("FAIL zero_sign got=%b exp=1", sign); end
    endtask

    task automatic test_busy();
        int lat, pulses;
        multiplicand = {1'b0, 30'd2};
        multiplier   = {1'b0, 30'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        multiplicand = {1'b0, 30'd9};
        multiplier   = {1'b0, 30'd9};
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        pulses = 0;
        for (int k = 5; k <= 20 && lat < 0; k++) begin
            tick();
            if (stop) lat = k;
        end
        checks++; if (lat !== 11)        begin errors++; $display("FAIL busy_latency got=%0d exp=11", lat); end
        checks++; if (product !== 60'd6) begin errors++; $display("FAIL busy_product got=%0d exp=6", product); end
        // New request issued during the stop cycle must be accepted.
        run_op({1'b0, 30'd9}, {1'b0, 30'd9}, lat, pulses);
        checks++; if (lat !== 11)         begin errors++; $display("FAIL busy_restart_latency got=%0d exp=11", lat); end
        checks++; if (product !== 60'd81) begin errors++; $display("FAIL busy_restart_product got=%0d exp=81", product); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        multiplicand = {1'b1, 30'd100};
        multiplier   = {1'b0, 30'd100};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (product !== 60'd0) begin errors++; $display("FAIL rstmid_product got=%0d exp=0", product); end
        checks++; if (sign !== 1'b0)     begin errors++; $display("FAIL rstmid_sign got=%b exp=0", sign); end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (stop) pulses++;
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_stop got=%0d exp=0", pulses); end
        run_op({1'b0, 30'd100}, {1'b0, 30'd100}, lat, pulses);
        checks++; if (lat !== 11)            begin errors++; $display("FAIL rstmid_fresh_latency got=%0d exp=11", lat); end
        checks++; if (product !== 60'd10000) begin errors++; $display("FAIL rstmid_fresh_product got=%0d exp=10000", product); end
    endtask

    task automatic test_back_to_back();
        int first, last, pulses;
        multiplicand = {1'b0, 30'd3};
        multiplier   = {1'b0, 30'd5};
        start = 1'b1;
        tick();
        first = -1;
        last  = -1;
        pulses = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (stop) begin
                if (first < 0) first = k;
                last = k;
                pulses++;
            end
        end
        start = 1'b0;
        checks++; if (first !== 11) begin errors++; $display("FAIL b2b_first got=%0d exp=11", first); end
        checks++; if (last !== 33)  begin errors++; $display("FAIL b2b_last got=%0d exp=33", last); end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        for (int k = 0; k < 14; k++) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_sign();
        test_zero();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul.md
Name: mul

Overview:
- MIX MUL (C=3) arithmetic unit. Sequential radix-8 shift-and-add multiplier using a start/stop handshake.
- Takes the signed-magnitude rA operand and the field-extracted memory operand V, and produces the 60-bit magnitude for rA:rX plus the result sign.
- Sits beside the DIV unit in the execution datapath. The sequencer pulses start, then waits for stop.

Parameters:
DIGITS, 10, number of radix-8 iterations; fixed at 30 magnitude bits / 3 bits per iteration. Not to be overridden.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only when idle
multiplicand  input  31  rA: bit 30 = sign (1 = minus), bits 29:0 = magnitude
multiplier  input  31  V: bit 30 = sign, bits 29:0 = magnitude
product  output  60  magnitude of result; bits 59:30 go to rA, bits 29:0 go to rX
sign  output  1  result sign, written to both rA and rX
stop  output  1  one-cycle completion pulse

Behaviour:
Reset:
- When reset is high at a clock edge: stop=0, sign=0, product=0, busy=0, iteration counter=0.
- Reset has priority over start and over any operation in flight.
- A reset mid-operation aborts it. No stop pulse is produced for the aborted operation.

States:
- IDLE (busy=0) and RUN (busy=1). The counter `state` counts 0..9.

Accept:
- Condition: cycle T with busy=0 and start=1.
- Latch sign <= multiplicand[30] ^ multiplier[30].
- Latch mcand <= multiplicand[29:0].
- Latch mplier shift register <= multiplier[29:0].
- Clear acc (60 bits) to 0; state <= 0; busy <= 1.
- Operands need only be valid during cycle T.

RUN iteration, edges T+1..T+10, most-significant octal digit first:
- acc <= acc*8 + mcand*mplier[29:27]
- mplier <= mplier << 3
- state <= state + 1

Width rules:
- After k iterations, acc < 2^30 * 8^k, so the final value fits in 60 bits. No overflow is possible and no overflow flag exists.
- The partial product mcand*digit is 33 bits and is zero-extended before the add.

Completion:
- On the edge where the iteration with state==9 executes, busy <= 0.
- On the following edge, stop <= 1 for exactly one cycle (stop high during cycle T+11, i.e. 11 cycles after start).
- Otherwise stop <= 0.

Outputs:
- product = acc.
- Intermediate values are visible while busy and are not meaningful.
- product and sign are valid from the stop cycle and hold until the next accepted start or reset.

Boundary conditions:
- start while busy: ignored. No restart, no state change.
- start in the same cycle that stop is high: accepted as a new operation (busy is already 0).
- Zero operand: product = 0. Sign is still the XOR of the input signs; MIX keeps minus zero.
- start held high continuously: a new operation is accepted each time the unit is idle, giving back-to-back operations every 11 cycles.

Optional Feature:
Macro: MUL_ZERO_BYPASS_EN
- Defined:
  - At accept, if multiplicand[29:0]==0 or multiplier[29:0]==0: acc <= 0, sign latched as usual, no RUN phase, stop pulses in cycle T+1.
  - Non-zero operands behave exactly as without the macro.
- Undefined: all operations take the full 11-cycle latency. Bypass logic is absent.

Test Plan:
- +3 * +5: start at T -> stop only at T+11; product=60'd15; sign=0.
- Max magnitudes, both positive: multiplicand=30'h3FFFFFFF, multiplier=30'h3FFFFFFF -> product=60'hFFFFFFF80000001, sign=0, stop at T+11.
- Sign handling:
  - -7 * +6 -> product=42, sign=1.
  - -7 * -6 -> product=42, sign=0.
- Zero operand: +0 * -5 -> product=0, sign=1.
  - Stop at T+11 without MUL_ZERO_BYPASS_EN.
  - Stop at T+1 with MUL_ZERO_BYPASS_EN.
- Busy protection: start +2*+3 at T, then pulse start with +9*+9 at T+4 -> stop only at T+11, product=6. Then start accepted at T+11 with +9*+9 -> product=81, stop at T+22.
- Reset mid-operation: start +100*+100 at T, reset at T+5 -> no stop pulse; product=0 and sign=0 from T+6. Then a fresh +100*+100 started at T+7 -> stop at T+18, product=10000.
